// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : alu_pkg                                              |
// | Description : Shared constants for the bit-serial ALU sequencer:   |
// |               operation codes, FSM states and cell op selects.     |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package alu_pkg;

  // Operation codes presented on alu_ctl
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  // Sequencer states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // 1-bit cell output select
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

endpackage
`default_nettype wire

// File: rtl/alu_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : alu_cell                                             |
// | Description : 1-bit ALU slice with operand inversion, full adder   |
// |               and AND/OR/sum/less output select.                   |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module alu_cell
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       ci,
  input  logic       less,
  input  logic [1:0] op,
  output logic       result,
  output logic       co
);

  logic w_a;
  logic w_b;
  logic w_sum;

  assign w_a   = a ^ a_invert;
  assign w_b   = b ^ b_invert;
  assign w_sum = w_a ^ w_b ^ ci;
  assign co    = (w_a & w_b) | (w_a & ci) | (w_b & ci);

  // Select the slice output according to op
  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = w_a & w_b;
      OP_OR:   result = w_a | w_b;
      OP_ADD:  result = w_sum;
      default: result = less;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : alu_ctl_decode                                       |
// | Description : Combinational map from alu_ctl to cell controls and  |
// |               operation class flags.                               |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [3:0] alu_ctl,
  output logic       a_invert,
  output logic       b_invert,
  output logic       carry_init,
  output logic [1:0] op,
  output logic       is_arith,
  output logic       is_slt,
  output logic       illegal
);

  // Illegal codes fall back to op=AND with no inversion; the output is discarded
  always_comb begin
    a_invert   = 1'b0;
    b_invert   = 1'b0;
    carry_init = 1'b0;
    op         = OP_AND;
    is_arith   = 1'b0;
    is_slt     = 1'b0;
    illegal    = 1'b0;
    case (alu_ctl)
      CTL_AND: op = OP_AND;
      CTL_OR:  op = OP_OR;
      CTL_ADD: begin
        op       = OP_ADD;
        is_arith = 1'b1;
      end
      CTL_SUB: begin
        b_invert   = 1'b1;
        carry_init = 1'b1;
        op         = OP_ADD;
        is_arith   = 1'b1;
      end
      CTL_SLT: begin
        b_invert   = 1'b1;
        carry_init = 1'b1;
        op         = OP_ADD;
        is_slt     = 1'b1;
      end
      CTL_NOR: begin
        a_invert = 1'b1;
        b_invert = 1'b1;
        op       = OP_AND;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : alu_serial_ctrl                                      |
// | Description : Bit-serial ALU sequencer; runs one 1-bit cell for    |
// |               WIDTH cycles per operation, LSB first, with SLT      |
// |               fix-up and zero/overflow/illegal status.             |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] a_sh_q,     a_sh_d;
  logic [WIDTH-1:0] b_sh_q,     b_sh_d;
  logic [3:0]       ctl_q,      ctl_d;
  logic             carry_q,    carry_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0] res_sh_q,   res_sh_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             zero_q,     zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q,  illegal_d;

  logic [3:0]       w_dec_ctl;
  logic             w_a_invert;
  logic             w_b_invert;
  logic             w_carry_init;
  logic [1:0]       w_op;
  logic             w_is_arith;
  logic             w_is_slt;
  logic             w_illegal;
  logic             w_cell_res;
  logic             w_cell_co;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_bits;
  logic             w_ov_raw;
  logic [WIDTH-1:0] w_final_res;
  logic             w_final_ov;

  // In IDLE the incoming code is decoded (for carry init); afterwards the latched one
  assign w_dec_ctl = (state_q == S_IDLE) ? alu_ctl : ctl_q;

  alu_ctl_decode u_decode (
    .alu_ctl    (w_dec_ctl),
    .a_invert   (w_a_invert),
    .b_invert   (w_b_invert),
    .carry_init (w_carry_init),
    .op         (w_op),
    .is_arith   (w_is_arith),
    .is_slt     (w_is_slt),
    .illegal    (w_illegal)
  );

  alu_cell u_cell (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .a_invert (w_a_invert),
    .b_invert (w_b_invert),
    .ci       (carry_q),
    .less     (1'b0),
    .op       (w_op),
    .result   (w_cell_res),
    .co       (w_cell_co)
  );

  // On the final bit, carry_q is the carry into the MSB and w_cell_co the carry out
  assign w_last     = (cnt_q == CW'(WIDTH - 1));
  assign w_sum_bits = {w_cell_res, res_sh_q[WIDTH-1:1]};
  assign w_ov_raw   = carry_q ^ w_cell_co;

  // Final result and overflow, applied while leaving RUN so outputs are registered in DONE
  always_comb begin
    w_final_res = w_sum_bits;
    w_final_ov  = 1'b0;
    if (w_illegal) begin
      w_final_res = '0;
    end else if (w_is_slt) begin
      // Sign of the true difference: sum MSB corrected by the overflow flag
      w_final_res = {{(WIDTH-1){1'b0}}, w_cell_res ^ w_ov_raw};
    end else if (w_is_arith) begin
      w_final_ov = w_ov_raw;
    end
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    ctl_d      = ctl_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    res_sh_d   = res_sh_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          ctl_d    = alu_ctl;
          carry_d  = w_carry_init;
          cnt_d    = '0;
          res_sh_d = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        res_sh_d = w_sum_bits;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = w_cell_co;
        cnt_d    = cnt_q + CW'(1);
        if (w_last) begin
          done_d     = 1'b1;
          result_d   = w_final_res;
          zero_d     = (w_final_res == '0);
          overflow_d = w_final_ov;
          illegal_d  = w_illegal;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset; reset aborts any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      ctl_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      res_sh_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      ctl_q      <= ctl_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      res_sh_q   <= res_sh_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;

endmodule
`default_nettype wire

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer. Time-multiplexes a single 1-bit ALU cell (a/b invert, carry in/out, AND/OR/add/less select) across WIDTH cycles to perform one WIDTH-bit operation.
- Owns the operand shift registers, the carry flop, operation decode, SLT fix-up and status flags.
- Sits between the decode/execute stage and the existing 1-bit cell. A single start/done handshake serves the requester.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CW, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- alu_ctl  input  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; all other codes illegal.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  held from DONE until the next accepted start.
- zero  output  1  result == 0; valid with result.
- overflow  output  1  signed overflow; ADD/SUB only, 0 otherwise.
- illegal  output  1  set when the accepted alu_ctl was an illegal code.

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - busy, done, result, zero, overflow and illegal = 0.
  - Shift registers, carry flop and counter = 0.
- Reset asserted mid-operation aborts immediately. No done is produced for the aborted request.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches a, b and alu_ctl, and clears the counter.
  - Carry flop loads 1 for SUB/SLT, 0 otherwise.
  - Go to RUN.
- RUN:
  - Each cycle processes bit index = counter, LSB first.
  - Cell inputs are the LSBs of the A and B shift registers and ci = carry flop.
  - Cell controls are decoded from the latched alu_ctl:
    - a_invert = ctl[3].
    - b_invert = ctl[2].
    - op = 00 for AND/NOR, 01 for OR, 10 for ADD/SUB/SLT.
    - The less input is tied to 0.
  - Cell result shifts into the result register MSB-side. co loads the carry flop. Operand registers shift right by 1.
  - On counter == WIDTH-1:
    - Capture ci of that bit as c_msb_in.
    - Capture co as c_out.
    - Go to DONE.
- DONE (exactly 1 cycle):
  - done=1 and busy=1.
  - overflow = c_msb_in ^ c_out for ADD/SUB, else 0.
  - SLT: result is replaced by {WIDTH-1 zeros, sum_msb ^ (c_msb_in ^ c_out)}. This gives a signed compare correct under overflow.
  - zero is computed on the final result.
  - Next state is IDLE.
- Latency: start sampled on edge E0. done is high during the cycle after edge E0+WIDTH (WIDTH+1 cycles total). Back-to-back start is accepted in the IDLE cycle following DONE.
- start while busy: ignored, no queuing. Operands and ctl changing while busy have no effect.
- Illegal alu_ctl: same latency. result=0, zero=1, overflow=0, illegal=1. The cell is still clocked with op=00 and its output is discarded.
- Arithmetic is modulo 2^WIDTH. The final carry out is not exposed except through overflow.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package alu_pkg holds:
  - The alu_ctl code constants (CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR).
  - The state enum (S_IDLE, S_RUN, S_DONE).
  - The op-select constants (OP_AND=00, OP_OR=01, OP_ADD=10, OP_LESS=11).
- Sub-module: alu_ctl_decode, a pure combinational map from alu_ctl to {a_invert, b_invert, carry_init, op, is_arith, is_slt, illegal}.
- The existing 1-bit alu_cell is instantiated once as the datapath.

Test Plan:
- WIDTH=8, ADD a=0x05 b=0x03, start pulsed at cycle 0 -> done high in cycle 9 only; result=0x08, zero=0, overflow=0; busy high cycles 1-9.
- WIDTH=8, SUB a=0x80 b=0x01 -> result=0x7F, overflow=1; ADD a=0x7F b=0x01 -> result=0x80, overflow=1; ADD 0xFF+0x01 -> result=0x00, zero=1, overflow=0.
- WIDTH=8, SLT a=0xFF(-1) b=0x01 -> result=0x01; SLT a=0x7F b=0x80 -> result=0x00 (overflow case); SLT a=b=0x10 -> result=0x00, zero=1.
- WIDTH=8, AND 0xF0&0x3C -> 0x30; OR -> 0xFC; NOR -> 0x03; alu_ctl=0101 -> result=0x00, zero=1, illegal=1, still done at cycle 9.
- Second start with different operands at cycle 4 during busy -> ignored; first result is unchanged and exactly one done pulse occurs. A start in the IDLE cycle right after DONE is accepted.
- rst asserted asynchronously in cycle 5 of a run -> all outputs 0 immediately and no done pulse. A new start after release completes normally in WIDTH+1 cycles.
